// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port data memory.
// Range-checks each access, holds it for the memory's latency and returns per-requester status.
module data_mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 64,
  parameter int DEPTH     = 64,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef struct packed {
    logic id;
    logic we;
    logic err;
  } own_t;

  // Limits carry one extra bit so BASE_ADDR+DEPTH never wraps.
  localparam logic [ADDR_W:0] ADDR_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] ADDR_HI = (ADDR_W+1)'(BASE_ADDR + DEPTH);

  state_t            state_q, state_d;
  own_t              own_q, own_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              win, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // ptr_q names the requester that wins a tie.
  always_comb begin
    win       = (req0 && req1) ? ptr_q : req1;
    sel_we    = win ? we1 : we0;
    sel_addr  = win ? addr1 : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_err   = ({1'b0, sel_addr} < ADDR_LO) || ({1'b0, sel_addr} >= ADDR_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      own_q    <= '0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: if (req0 || req1) begin
        own_d    = '{id: win, we: sel_we, err: sel_err};
        maddr_d  = sel_addr;
        mwdata_d = sel_wdata;
        ptr_d    = ~win;
        state_d  = ACCESS;
      end
      ACCESS: begin
        cnt_d   = 2'(READ_LAT - 1);
        state_d = (own_q.we || own_q.err) ? DONE : WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        if (own_q.id) rdata1_d = mem_read_data;
        else          rdata0_d = mem_read_data;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0             = (state_q == ACCESS) && !own_q.id;
    gnt1             = (state_q == ACCESS) &&  own_q.id;
    done0            = (state_q == DONE)   && !own_q.id;
    done1            = (state_q == DONE)   &&  own_q.id;
    err0             = done0 && own_q.err;
    err1             = done1 && own_q.err;
    mem_write_enable = (state_q == ACCESS) && own_q.we && !own_q.err;
    busy             = (state_q != IDLE);
  end

  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 8-bit data memory (64 lines, byte addresses 64..127).
- Shares the memory between requester 0 (core load/store unit) and requester 1 (loader/debug port) with a req/gnt/done handshake.
- Range-checks every address before the access is issued.
- Holds each access for exactly the cycles the memory needs, and returns read data and error status per requester.

Parameters:
- ADDR_W, 8, address width of requesters and memory port
- DATA_W, 8, data width
- BASE_ADDR, 64, lowest valid memory address
- DEPTH, 64, number of valid lines; valid range is BASE_ADDR..BASE_ADDR+DEPTH-1
- READ_LAT, 1, cycles from mem_address driven to mem_read_data valid (legal range 1..3)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held until gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  access address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse; request accepted
- done0 / done1  out  1  one-cycle pulse; access complete
- err0 / err1  out  1  valid with done; 1 = address out of range
- rdata0 / rdata1  out  DATA_W  read result; valid from done, held until next read completion for that requester
- mem_address  out  ADDR_W  to memory data_address
- mem_write_data  out  DATA_W  to memory write_data
- mem_write_enable  out  1  to memory write_enable
- mem_read_data  in  DATA_W  from memory read_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; round-robin pointer favours requester 0; all gnt/done/err outputs 0; rdata0/1 = 0; mem_address = 0; mem_write_data = 0; mem_write_enable = 0; busy = 0.
- Output timing: all outputs are registered or decoded from registered state only. There is no combinational path from any req/addr/we input to any output.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high at a rising edge, pick the winner. If one requester asks, it wins. If both ask, the pointer decides.
  - Latch the winner's id, we, addr and wdata, plus range_err = (addr < BASE_ADDR) or (addr >= BASE_ADDR+DEPTH). Go to ACCESS.
  - After each grant, the pointer moves to favour the other requester.
- ACCESS (exactly 1 cycle):
  - gnt of the owner = 1. mem_address and mem_write_data take the latched values.
  - mem_write_enable = latched we AND NOT range_err.
  - Next state: DONE if write or range_err; otherwise WAIT.
- WAIT (READ_LAT cycles, counted):
  - mem_address held, mem_write_enable = 0.
  - At the edge ending the last WAIT cycle, mem_read_data is captured into the owner's rdata. Go to DONE.
- DONE (1 cycle):
  - done of the owner = 1 and err of the owner = range_err. Go to IDLE.
  - No arbitration happens in DONE.
- Latency from the sampling edge of req:
  - Write: gnt in cycle +1, done in cycle +2.
  - Read: gnt in cycle +1, done in cycle +2+READ_LAT.
  - Error: gnt in cycle +1, done/err in cycle +2.
  - Minimum spacing between grants: writes 3 cycles; reads 3+READ_LAT cycles.
- Request protocol:
  - A requester drops req in the cycle after it sees gnt.
  - If req is still high when IDLE is re-entered, it is treated as a new request.
  - The non-winning requester keeps req asserted and is served next. It cannot starve: with both requesters requesting continuously, grants alternate.
- Idle port values: mem_address and mem_write_data hold their last values; mem_write_enable = 0 outside ACCESS.
- Out-of-range access: the memory is never written. rdata of that requester is unchanged, even for a read.
- Reset mid-operation:
  - All outputs return to reset values immediately and asynchronously, including mem_write_enable = 0.
  - No done is issued for the aborted access.
  - A write commits only if rst_n is high at the edge ending ACCESS.
- Address arithmetic: comparisons are unsigned at ADDR_W bits. BASE_ADDR+DEPTH is computed at ADDR_W+1 bits, so it does not wrap.

Test Plan:
- Reset: assert rst_n=0 during a write ACCESS cycle -> mem_write_enable, gnt0 and busy drop to 0 immediately; no done0; the next request is granted normally.
- Write then read, req0: write addr 70, data 0xA5 -> gnt0 and mem_write_enable=1 with mem_address=70 in cycle +1; done0=1, err0=0 in cycle +2. Then read addr 70 -> done0 in cycle +3 with rdata0=0xA5.
- Contention: req0 and req1 rise together after reset -> requester 0 granted first, requester 1 next. With both held for 4 transactions, grants go 0,1,0,1.
- Range check: req1 write to addr 63, then addr 128 -> each gives done1=1 and err1=1; mem_write_enable never asserts; a later read of 64..127 shows no change.
- Boundaries: write/read addr 64 (0x11) and addr 127 (0xEE) -> err=0 and correct readback for both.
- Parameter READ_LAT=2: read addr 100 -> done in cycle +4; rdata is captured after exactly 2 WAIT cycles.
